// File: rtl/turtle_mmio_pkg.sv
// turtle_mmio_pkg: register offsets, bit indices and STATUS layout for the MMIO responder
package turtle_mmio_pkg;
    localparam logic [3:0] OFS_LED   = 4'h0;
    localparam logic [3:0] OFS_SW    = 4'h1;
    localparam logic [3:0] OFS_TCTRL = 4'h2;
    localparam logic [3:0] OFS_TCMP  = 4'h3;
    localparam logic [3:0] OFS_TCNT  = 4'h4;
    localparam logic [3:0] OFS_STAT  = 4'h5;
    localparam logic [3:0] OFS_TXD   = 4'h6;
    localparam int TC_EN    = 0;
    localparam int TC_AR    = 1;
    localparam int ST_FLAG  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    typedef struct packed {
        logic [3:0] count;
        logic       tx_ovf;
        logic       fifo_empty;
        logic       fifo_full;
        logic       tmr_flag;
    } status_t;
endpackage

// File: rtl/turtle_mmio_responder_if.sv
// turtle_mmio_if: CPU external data bus (address, store strobe/data, read data, internal-memory select)
// master = CPU side, slave = responder side
interface turtle_mmio_if #(
    parameter int DATA_W   = 8,
    parameter int D_ADDR_W = 12
);
    logic [D_ADDR_W-1:0] data_addr;
    logic                write_enable;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   read_data;
    logic                int_mem_select;
    modport master(output data_addr, write_enable, write_data, input read_data, int_mem_select);
    modport slave(input data_addr, write_enable, write_data, output read_data, int_mem_select);
endinterface

// File: rtl/turtle_mmio_responder_fifo.sv
// mmio_tx_fifo: synchronous byte FIFO with push/pop, full/empty and occupancy count
// ports: clk, reset (async, active-high), push/din, pop/dout (head), full, empty, count
module mmio_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/turtle_mmio_responder.sv
// turtle_mmio_responder: 16-byte I/O window with LEDs, synced switches, prescaled timer and TX FIFO stream
// ports: clk, reset (async, active-high), bus (slave: data_addr/write_enable/write_data/read_data/int_mem_select),
//        led, sw_in, tx_data/tx_valid/tx_ready (TX stream), timer_irq
module turtle_mmio_responder
    import turtle_mmio_pkg::*;
#(
    parameter int                  DATA_W     = 8,
    parameter int                  D_ADDR_W   = 12,
    parameter logic [D_ADDR_W-1:0] IO_BASE    = 12'hFF0,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  PRESCALE   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    turtle_mmio_if.slave      bus,
    output logic [DATA_W-1:0] led,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              timer_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(PRESCALE + 1);
    logic              in_win, wr;
    logic [3:0]        ofs;
    logic [DATA_W-1:0] sw_s1, sw_s2, tmr_cmp, tmr_cnt, rd;
    logic [1:0]        tmr_ctrl;
    logic              tmr_flag, tx_ovf;
    logic [PW-1:0]     pre;
    logic              tick, flag_set, push, pop, full, empty, ovf_set;
    logic [CW-1:0]     count;
    status_t           status;
    assign in_win             = bus.data_addr[D_ADDR_W-1:4] == IO_BASE[D_ADDR_W-1:4];
    assign ofs                = bus.data_addr[3:0];
    assign wr                 = bus.write_enable & in_win;
    assign bus.int_mem_select = ~in_win;
    assign tick               = tmr_ctrl[TC_EN] && pre == PW'(PRESCALE - 1);
    assign flag_set           = tick && tmr_cnt == tmr_cmp;
    assign tx_valid           = ~empty;
    assign pop                = tx_valid & tx_ready;
    assign push               = wr && ofs == OFS_TXD;
    assign ovf_set            = push & full & ~pop;
    assign timer_irq          = tmr_flag;
    assign status             = '{count: 4'(count), tx_ovf: tx_ovf, fifo_empty: empty,
                                  fifo_full: full, tmr_flag: tmr_flag};
    mmio_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .din(bus.write_data), .pop(pop),
        .dout(tx_data), .full(full), .empty(empty), .count(count)
    );
    always_comb begin
        rd = '0;
        case (ofs)
            OFS_LED:   rd = led;
            OFS_SW:    rd = sw_s2;
            OFS_TCTRL: rd = DATA_W'(tmr_ctrl);
            OFS_TCMP:  rd = tmr_cmp;
            OFS_TCNT:  rd = tmr_cnt;
            OFS_STAT:  rd = DATA_W'(status);
            default:   rd = '0;
        endcase
        bus.read_data = in_win ? rd : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            tmr_ctrl <= '0;
            tmr_cmp  <= '0;
            tmr_cnt  <= '0;
            tmr_flag <= 1'b0;
            tx_ovf   <= 1'b0;
            pre      <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
            // prescaler idles at 0 while disabled so the first tick is a full period after enable
            pre <= (tmr_ctrl[TC_EN] && !tick) ? pre + 1'b1 : '0;
            if (wr && ofs == OFS_LED) led <= bus.write_data;
            if (wr && ofs == OFS_TCTRL) tmr_ctrl <= bus.write_data[1:0];
            if (wr && ofs == OFS_TCMP) tmr_cmp <= bus.write_data;
            if (wr && ofs == OFS_TCNT) tmr_cnt <= bus.write_data;
            else if (tick) tmr_cnt <= (flag_set && tmr_ctrl[TC_AR]) ? '0 : tmr_cnt + 1'b1;
            // set events beat a simultaneous write-1-to-clear
            tmr_flag <= flag_set | (tmr_flag & ~(wr && ofs == OFS_STAT && bus.write_data[ST_FLAG]));
            tx_ovf   <= ovf_set | (tx_ovf & ~(wr && ofs == OFS_STAT && bus.write_data[ST_OVF]));
        end
    end
endmodule

// File: doc/turtle_mmio_responder.md
Name: turtle_mmio_responder

Overview:
Memory-mapped I/O responder on the turtle_cpu_subsystem external data interface. It sits opposite the CPU data port: it decodes data_addr and selects internal memory or I/O through int_mem_select. It serves read_data for a 16-byte register window containing LED output, synchronised switch input, a prescaled 8-bit timer with compare flag/IRQ, and a TX byte FIFO drained over a valid/ready stream.

Parameters:
DATA_W, 8, data width; the register map assumes 8.
D_ADDR_W, 12, data address width.
IO_BASE, 12'hFF0, window base; low 4 bits ignored, window is IO_BASE[11:4] plus 16 offsets.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
PRESCALE, 1000, clk cycles per timer tick; at least 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_addr  in  D_ADDR_W  CPU data address
write_enable  in  1  CPU store strobe
write_data  in  DATA_W  CPU store data
read_data  out  DATA_W  I/O read data, combinational
int_mem_select  out  1  1 = CPU uses internal dmem; 0 = address is in the I/O window
led  out  DATA_W  LED_OUT register
sw_in  in  DATA_W  asynchronous switches
tx_data  out  DATA_W  FIFO head
tx_valid  out  1  FIFO not empty
tx_ready  in  1  consumer accepts head
timer_irq  out  1  equals STATUS.tmr_flag

Behaviour:
- Decode: in_win = (data_addr[D_ADDR_W-1:4] == IO_BASE[D_ADDR_W-1:4]). int_mem_select = ~in_win, combinational.
- Reads: combinational, with no side effects. read_data = reg[offset] when in_win, else 0. Unmapped offsets read 0.
- Writes: take effect at the clk edge when write_enable & in_win. Writes to read-only or unmapped offsets are ignored.
- Register map:
  - 0x0 LED_OUT: RW; drives led.
  - 0x1 SW_IN: RO; 2-flop synchronised sw_in.
  - 0x2 TMR_CTRL: RW; bit0 en, bit1 autoreload, other bits read 0.
  - 0x3 TMR_CMP: RW.
  - 0x4 TMR_CNT: RW; a write loads the count.
  - 0x5 STATUS: bit0 tmr_flag (W1C), bit1 fifo_full, bit2 fifo_empty, bit3 tx_ovf (W1C), bits[7:4] fifo count.
  - 0x6 TX_DATA: WO, reads 0; a write pushes one byte.
- Reset values: all registers, sync flops, prescaler and FIFO pointers clear to 0. As a result led=0, tx_valid=0, timer_irq=0, and STATUS reads 0x04.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1; tick is a 1-cycle pulse on wrap.
  - Held at 0 while en=0, so the first tick comes PRESCALE cycles after enable.
- Timer on tick:
  - If cnt==cmp: tmr_flag<=1, and cnt<=0 if autoreload, else cnt+1.
  - Otherwise cnt<=cnt+1, wrapping 255→0.
  - A CPU write to TMR_CNT in the same cycle wins over the tick increment; the flag still evaluates against the old cnt.
- W1C priority: writing 1 to tmr_flag or tx_ovf clears it unless a set event occurs in the same cycle; set wins.
- FIFO pop: occurs when tx_valid & tx_ready.
- FIFO push: occurs on a TX_DATA write.
  - If full and no pop in the same cycle, the byte is dropped and tx_ovf<=1.
  - Full with a simultaneous pop: the push is accepted and count is unchanged.
  - Empty with a simultaneous push: no pop; tx_valid rises the next cycle. Push-to-valid latency is 1 cycle.
- Stream stability: tx_data and tx_valid are stable while tx_valid & ~tx_ready.
- Reset mid-operation: async clear of all state immediately. In-flight FIFO contents are discarded, tx_valid drops at once and the timer stops.

Decomposition:
- turtle_mmio_pkg holds:
  - offset localparams: OFS_LED, OFS_SW, OFS_TCTRL, OFS_TCMP, OFS_TCNT, OFS_STAT, OFS_TXD
  - TMR_CTRL and STATUS bit-index constants
  - a packed status_t struct
- Sub-module mmio_tx_fifo (sync FIFO with push/pop/full/empty/count, async active-high reset), instantiated once.

Test Plan:
- Reset → read_data=0 at 0xFF0; STATUS (0xFF5) reads 0x04; led=0, tx_valid=0, int_mem_select=0 at 0xFF5 and 1 at 0x123.
- Write 0xA5 to 0xFF0, then drive sw_in=0x3C → led=0xA5 next cycle; 0xFF1 reads 0x3C within 2 cycles; writes to 0x0F0 leave led unchanged.
- PRESCALE=4, CMP=2, CTRL=0x3 → cnt 0,1,2 at ticks 4, 8 and 12 cycles after enable. The 3rd tick sets timer_irq and reloads cnt to 0. Writing 0x01 to STATUS clears the flag; with autoreload=0 cnt advances to 3.
- Hold tx_ready=0 and push 0x11,0x22,0x33,0x44,0x55 → STATUS=0x4A (count 4, full, tx_ovf); 0x55 is dropped. Raise tx_ready → 0x11..0x44 drain one per cycle, then empty.
- FIFO full, push 0x66 in the same cycle as a pop → count stays 4 and the last entry drained is 0x66. Empty FIFO with push plus tx_ready=1 → tx_valid rises the next cycle.
- Assert reset mid-drain with the timer enabled → tx_valid=0, timer_irq=0 and led=0 immediately (before the next edge); STATUS reads 0x04 after release.
